// File: rtl/wb_arbiter_2m1s.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_2m1s
//  Brief    : Wishbone interconnect, two masters (I-cache, D-cache) sharing
//             one slave. Round-robin arbitration with bus lock held for as
//             long as the owning master keeps cyc asserted.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_2m1s #(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int BLW = 10
) (
   input  logic              clk_i,
   input  logic              rst_n,

   // Master 0 (instruction cache)
   input  logic [DW-1:0]     m0_wbd_dat_i,
   input  logic [AW-1:0]     m0_wbd_adr_i,
   input  logic [DW/8-1:0]   m0_wbd_sel_i,
   input  logic              m0_wbd_we_i,
   input  logic              m0_wbd_cyc_i,
   input  logic              m0_wbd_stb_i,
   output logic [DW-1:0]     m0_wbd_dat_o,
   output logic              m0_wbd_ack_o,
   output logic              m0_wbd_lack_o,
   output logic              m0_wbd_err_o,

   // Master 1 (data cache, burst capable)
   input  logic [DW-1:0]     m1_wbd_dat_i,
   input  logic [AW-1:0]     m1_wbd_adr_i,
   input  logic [DW/8-1:0]   m1_wbd_sel_i,
   input  logic              m1_wbd_we_i,
   input  logic              m1_wbd_cyc_i,
   input  logic              m1_wbd_stb_i,
   input  logic [BLW-1:0]    m1_wbd_bl_i,
   input  logic              m1_wbd_bry_i,
   output logic [DW-1:0]     m1_wbd_dat_o,
   output logic              m1_wbd_ack_o,
   output logic              m1_wbd_lack_o,
   output logic              m1_wbd_err_o,

   // Shared slave
   input  logic [DW-1:0]     s_wbd_dat_i,
   input  logic              s_wbd_ack_i,
   input  logic              s_wbd_lack_i,
   output logic [DW-1:0]     s_wbd_dat_o,
   output logic [AW-1:0]     s_wbd_adr_o,
   output logic [DW/8-1:0]   s_wbd_sel_o,
   output logic [BLW-1:0]    s_wbd_bl_o,
   output logic              s_wbd_bry_o,
   output logic              s_wbd_we_o,
   output logic              s_wbd_cyc_o,
   output logic              s_wbd_stb_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   // 1 = master1 was served last, so master0 wins the next tie.
   logic   last_q, last_d;

   // Owner and last-served registers; reset parks the bus in IDLE.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Arbitration: grant from IDLE, hold while owner keeps cyc, hand over on release.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (m0_wbd_cyc_i && m1_wbd_cyc_i) begin
               state_d = last_q ? ST_OWN0 : ST_OWN1;
            end else if (m0_wbd_cyc_i) begin
               state_d = ST_OWN0;
            end else if (m1_wbd_cyc_i) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN0: begin
            if (!m0_wbd_cyc_i) begin
               last_d  = 1'b0;
               state_d = m1_wbd_cyc_i ? ST_OWN1 : ST_IDLE;
            end
         end
         ST_OWN1: begin
            if (!m1_wbd_cyc_i) begin
               last_d  = 1'b1;
               state_d = m0_wbd_cyc_i ? ST_OWN0 : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request path: forward only the owner's signals; master0 has no burst, so it looks like single-beat bursts.
   always_comb begin
      s_wbd_dat_o = '0;
      s_wbd_adr_o = '0;
      s_wbd_sel_o = '0;
      s_wbd_bl_o  = '0;
      s_wbd_bry_o = 1'b0;
      s_wbd_we_o  = 1'b0;
      s_wbd_cyc_o = 1'b0;
      s_wbd_stb_o = 1'b0;
      case (state_q)
         ST_OWN0: begin
            s_wbd_dat_o = m0_wbd_dat_i;
            s_wbd_adr_o = m0_wbd_adr_i;
            s_wbd_sel_o = m0_wbd_sel_i;
            s_wbd_bl_o  = {{(BLW-1){1'b0}}, 1'b1};
            s_wbd_bry_o = 1'b1;
            s_wbd_we_o  = m0_wbd_we_i;
            s_wbd_cyc_o = m0_wbd_cyc_i;
            s_wbd_stb_o = m0_wbd_stb_i;
         end
         ST_OWN1: begin
            s_wbd_dat_o = m1_wbd_dat_i;
            s_wbd_adr_o = m1_wbd_adr_i;
            s_wbd_sel_o = m1_wbd_sel_i;
            s_wbd_bl_o  = m1_wbd_bl_i;
            s_wbd_bry_o = m1_wbd_bry_i;
            s_wbd_we_o  = m1_wbd_we_i;
            s_wbd_cyc_o = m1_wbd_cyc_i;
            s_wbd_stb_o = m1_wbd_stb_i;
         end
         default: ;
      endcase
   end

   // Response path: slave data/acks reach the owner only, with no added latency.
   always_comb begin
      m0_wbd_dat_o  = '0;
      m0_wbd_ack_o  = 1'b0;
      m0_wbd_lack_o = 1'b0;
      m1_wbd_dat_o  = '0;
      m1_wbd_ack_o  = 1'b0;
      m1_wbd_lack_o = 1'b0;
      if (state_q == ST_OWN0) begin
         m0_wbd_dat_o  = s_wbd_dat_i;
         m0_wbd_ack_o  = s_wbd_ack_i;
         m0_wbd_lack_o = s_wbd_lack_i;
      end
      if (state_q == ST_OWN1) begin
         m1_wbd_dat_o  = s_wbd_dat_i;
         m1_wbd_ack_o  = s_wbd_ack_i;
         m1_wbd_lack_o = s_wbd_lack_i;
      end
   end

   // No address decode behind this interconnect, so nothing can raise an error.
   assign m0_wbd_err_o = 1'b0;
   assign m1_wbd_err_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m1s.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter_2m1s
//  Brief    : Self-checking bench for wb_arbiter_2m1s: directed scenarios
//             plus randomized traffic against an ownership reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2m1s;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int BLW = 10;
   localparam int SW  = DW + AW + DW/8 + BLW + 4;

   logic clk_i = 1'b0;
   logic rst_n;
   logic [DW-1:0] m0_dat, m1_dat, s_dat;
   logic [AW-1:0] m0_adr, m1_adr;
   logic [DW/8-1:0] m0_sel, m1_sel;
   logic m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
   logic [BLW-1:0] m1_bl;
   logic m1_bry, s_ack, s_lack;
   wire [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
   wire m0_ack_o, m0_lack_o, m0_err_o, m1_ack_o, m1_lack_o, m1_err_o;
   wire [AW-1:0] s_adr_o;
   wire [DW/8-1:0] s_sel_o;
   wire [BLW-1:0] s_bl_o;
   wire s_bry_o, s_we_o, s_cyc_o, s_stb_o;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: who owns the bus (-1 none) and who was served last.
   int mdl_owner;
   int mdl_last;

   wb_arbiter_2m1s #(.DW(DW), .AW(AW), .BLW(BLW)) dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .m0_wbd_dat_i(m0_dat), .m0_wbd_adr_i(m0_adr), .m0_wbd_sel_i(m0_sel),
      .m0_wbd_we_i(m0_we), .m0_wbd_cyc_i(m0_cyc), .m0_wbd_stb_i(m0_stb),
      .m0_wbd_dat_o(m0_dat_o), .m0_wbd_ack_o(m0_ack_o), .m0_wbd_lack_o(m0_lack_o),
      .m0_wbd_err_o(m0_err_o),
      .m1_wbd_dat_i(m1_dat), .m1_wbd_adr_i(m1_adr), .m1_wbd_sel_i(m1_sel),
      .m1_wbd_we_i(m1_we), .m1_wbd_cyc_i(m1_cyc), .m1_wbd_stb_i(m1_stb),
      .m1_wbd_bl_i(m1_bl), .m1_wbd_bry_i(m1_bry),
      .m1_wbd_dat_o(m1_dat_o), .m1_wbd_ack_o(m1_ack_o), .m1_wbd_lack_o(m1_lack_o),
      .m1_wbd_err_o(m1_err_o),
      .s_wbd_dat_i(s_dat), .s_wbd_ack_i(s_ack), .s_wbd_lack_i(s_lack),
      .s_wbd_dat_o(s_dat_o), .s_wbd_adr_o(s_adr_o), .s_wbd_sel_o(s_sel_o),
      .s_wbd_bl_o(s_bl_o), .s_wbd_bry_o(s_bry_o), .s_wbd_we_o(s_we_o),
      .s_wbd_cyc_o(s_cyc_o), .s_wbd_stb_o(s_stb_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, time=%0t required < 1000000", $time);
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      mdl_owner = -1;
      mdl_last  = 1;
   endtask

   // One arbitration decision: round-robin among requesters when free,
   // otherwise keep the owner until it releases cyc.
   task automatic model_step(input logic c0, input logic c1);
      bit req[2];
      req[0] = c0;
      req[1] = c1;
      if (mdl_owner < 0) begin
         if (req[0] && req[1]) mdl_owner = 1 - mdl_last;
         else if (req[0])      mdl_owner = 0;
         else if (req[1])      mdl_owner = 1;
      end else if (!req[mdl_owner]) begin
         mdl_last  = mdl_owner;
         mdl_owner = req[1 - mdl_owner] ? 1 - mdl_owner : -1;
      end
   endtask

   // Advance one clock; leaves time at rising edge + 1.
   task automatic tick();
      logic c0, c1;
      c0 = m0_cyc;
      c1 = m1_cyc;
      @(posedge clk_i);
      if (rst_n) model_step(c0, c1);
      #1;
   endtask

   task automatic clear_inputs();
      m0_dat = '0; m0_adr = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
      m1_dat = '0; m1_adr = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
      m1_bl = '0; m1_bry = 0; s_dat = '0; s_ack = 0; s_lack = 0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1; s_dat = 32'h1234_5678;
      tick();
      tests_run++;
      if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_bl_o, s_bry_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_slave_outs: got cyc=%b adr=%h bl=%h, required all 0", s_cyc_o, s_adr_o, s_bl_o);
      end
      tests_run++;
      if ({m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_master_outs: got ack0=%b ack1=%b dat0=%h, required 0", m0_ack_o, m1_ack_o, m0_dat_o);
      end
      reset_dut();
   endtask

   task automatic test_m0_read();
      reset_dut();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
      #1;
      tests_run++;
      if (s_cyc_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL m0_read_latency: s_cyc=%b, required 0 before grant", s_cyc_o);
      end
      tick();
      tests_run++;
      if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h100 || s_bl_o !== 10'd1 || s_bry_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL m0_read_grant: cyc=%b adr=%h bl=%0d bry=%b, required 1 100 1 1", s_cyc_o, s_adr_o, s_bl_o, s_bry_o);
      end
      s_dat = 32'hDEAD_BEEF; s_ack = 1; s_lack = 1;
      #1;
      tests_run++;
      if (m0_dat_o !== 32'hDEAD_BEEF || m0_ack_o !== 1'b1 || m0_lack_o !== 1'b1 || m1_ack_o !== 1'b0 || m1_dat_o !== '0) begin
         tests_failed++;
         $display("FAIL m0_read_resp: dat0=%h ack0=%b lack0=%b ack1=%b dat1=%h, required deadbeef 1 1 0 0", m0_dat_o, m0_ack_o, m0_lack_o, m1_ack_o, m1_dat_o);
      end
      m0_cyc = 0; m0_stb = 0;
      #1;
      tests_run++;
      if (m0_ack_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL m0_drop_ack: ack0=%b, required 1 until clock edge", m0_ack_o);
      end
      tick();
      s_ack = 0; s_lack = 0;
   endtask

   task automatic test_m1_write();
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h1000; m1_dat = 32'h1; m1_sel = 4'hF;
      m1_bl = 10'd4; m1_bry = 1;
      tick();
      tests_run++;
      if (s_we_o !== 1'b1 || s_dat_o !== 32'h1 || s_bl_o !== 10'd4 || s_sel_o !== 4'hF || s_adr_o !== 32'h1000) begin
         tests_failed++;
         $display("FAIL m1_write: we=%b dat=%h bl=%0d sel=%h adr=%h, required 1 1 4 f 1000", s_we_o, s_dat_o, s_bl_o, s_sel_o, s_adr_o);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_tie();
      reset_dut();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
      tick();
      tests_run++;
      if (s_adr_o !== 32'hA0) begin
         tests_failed++;
         $display("FAIL tie_first: adr=%h, required a0 (m0)", s_adr_o);
      end
      m0_cyc = 0; m0_stb = 0;
      tick();
      tests_run++;
      if (s_adr_o !== 32'hB0 || s_cyc_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL tie_handover: adr=%h cyc=%b, required b0 1", s_adr_o, s_cyc_o);
      end
      m1_cyc = 0; m1_stb = 0;
      tick();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      tests_run++;
      if (s_adr_o !== 32'hA0) begin
         tests_failed++;
         $display("FAIL tie_again: adr=%h, required a0 (m0)", s_adr_o);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_lock();
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h2000; m1_bl = 10'd4; m1_bry = 1;
      tick();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
      for (int i = 0; i < 4; i++) begin
         s_ack = 1; s_dat = 32'hC0DE_0000 + i;
         #1;
         tests_run++;
         if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || s_adr_o !== 32'h2000 || m1_dat_o !== 32'hC0DE_0000 + i) begin
            tests_failed++;
            $display("FAIL lock_beat%0d: ack1=%b ack0=%b adr=%h dat1=%h, required 1 0 2000 %h", i, m1_ack_o, m0_ack_o, s_adr_o, m1_dat_o, 32'hC0DE_0000 + i);
         end
         tick();
      end
      m1_cyc = 0; m1_stb = 0; s_ack = 0;
      tick();
      tests_run++;
      if (s_adr_o !== 32'h300 || s_cyc_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_release: adr=%h cyc=%b, required 300 1", s_adr_o, s_cyc_o);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h44;
      tick();
      s_ack = 1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if (s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: cyc=%b ack1=%b ack0=%b, required 0 0 0", s_cyc_o, m1_ack_o, m0_ack_o);
      end
      clear_inputs();
      tick();
      rst_n = 1'b1;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h55;
      tick();
      tests_run++;
      if (s_adr_o !== 32'h55 || s_cyc_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_regrant: adr=%h cyc=%b, required 55 1", s_adr_o, s_cyc_o);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_idle_ack();
      s_ack = 1; s_lack = 1; s_dat = 32'hFFFF_FFFF;
      #1;
      tests_run++;
      if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0 || m1_err_o !== 1'b0 || s_cyc_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_ack: ack0=%b ack1=%b err0=%b err1=%b cyc=%b, required all 0", m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_cyc_o);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_random();
      logic [SW-1:0] exp_s, act_s;
      logic [DW+1:0] exp_m0, exp_m1;
      int errs_seen;
      errs_seen = 0;
      for (int n = 0; n < 300; n++) begin
         m0_dat = $urandom; m0_adr = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
         m0_cyc = ($urandom_range(0, 3) != 0); m0_stb = 1'($urandom);
         m1_dat = $urandom; m1_adr = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
         m1_cyc = ($urandom_range(0, 3) != 0); m1_stb = 1'($urandom);
         m1_bl = 10'($urandom); m1_bry = 1'($urandom);
         s_dat = $urandom; s_ack = 1'($urandom); s_lack = 1'($urandom);
         #4;
         exp_s = '0; exp_m0 = '0; exp_m1 = '0;
         if (mdl_owner == 0) begin
            exp_s  = {m0_dat, m0_adr, m0_sel, 10'd1, 1'b1, m0_we, m0_cyc, m0_stb};
            exp_m0 = {s_dat, s_ack, s_lack};
         end else if (mdl_owner == 1) begin
            exp_s  = {m1_dat, m1_adr, m1_sel, m1_bl, m1_bry, m1_we, m1_cyc, m1_stb};
            exp_m1 = {s_dat, s_ack, s_lack};
         end
         act_s = {s_dat_o, s_adr_o, s_sel_o, s_bl_o, s_bry_o, s_we_o, s_cyc_o, s_stb_o};
         tests_run++;
         if (act_s !== exp_s) begin
            tests_failed++;
            $display("FAIL rand_slave[%0d] owner=%0d: got %h, required %h", n, mdl_owner, act_s, exp_s);
         end
         tests_run++;
         if ({m0_dat_o, m0_ack_o, m0_lack_o} !== exp_m0 || {m1_dat_o, m1_ack_o, m1_lack_o} !== exp_m1) begin
            tests_failed++;
            $display("FAIL rand_resp[%0d] owner=%0d: got m0=%h m1=%h, required m0=%h m1=%h", n, mdl_owner,
                     {m0_dat_o, m0_ack_o, m0_lack_o}, {m1_dat_o, m1_ack_o, m1_lack_o}, exp_m0, exp_m1);
         end
         if (m0_err_o !== 1'b0 || m1_err_o !== 1'b0) errs_seen++;
         tick();
      end
      tests_run++;
      if (errs_seen !== 0) begin
         tests_failed++;
         $display("FAIL rand_err: err asserted in %0d cycles, required 0", errs_seen);
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_m0_read();
      test_m1_write();
      test_tie();
      test_lock();
      test_reset_mid();
      test_idle_ack();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_2m1s.md
Name: wb_arbiter_2m1s

Overview:
- Wishbone interconnect joining two masters to one shared slave (memory).
- Master 0 is the instruction-cache port. Master 1 is the data-cache port, which adds burst-length and burst-ready signals.
- Round-robin arbiter with bus lock. Address, data and control of the granted master go to the slave. Slave responses return to the granted master only.

Parameters:
- DW, 32, data width
- AW, 32, address width
- BLW, 10, burst-length width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_wbd_dat_i  in  DW  master0 write data
- m0_wbd_adr_i  in  AW  master0 address
- m0_wbd_sel_i  in  DW/8  master0 byte select
- m0_wbd_we_i  in  1  master0 write enable
- m0_wbd_cyc_i  in  1  master0 cycle
- m0_wbd_stb_i  in  1  master0 strobe
- m0_wbd_dat_o  out  DW  master0 read data
- m0_wbd_ack_o  out  1  master0 ack
- m0_wbd_lack_o  out  1  master0 last-ack
- m0_wbd_err_o  out  1  master0 error
- m1_wbd_dat_i, m1_wbd_adr_i, m1_wbd_sel_i, m1_wbd_we_i, m1_wbd_cyc_i, m1_wbd_stb_i  in  same widths as master0
- m1_wbd_bl_i  in  BLW  master1 burst length
- m1_wbd_bry_i  in  1  master1 burst ready
- m1_wbd_dat_o, m1_wbd_ack_o, m1_wbd_lack_o, m1_wbd_err_o  out  same as master0
- s_wbd_dat_i  in  DW  slave read data
- s_wbd_ack_i  in  1  slave ack
- s_wbd_lack_i  in  1  slave last-ack
- s_wbd_dat_o  out  DW  slave write data
- s_wbd_adr_o  out  AW  slave address
- s_wbd_sel_o  out  DW/8  slave byte select
- s_wbd_bl_o  out  BLW  slave burst length
- s_wbd_bry_o  out  1  slave burst ready
- s_wbd_we_o  out  1  slave write enable
- s_wbd_cyc_o  out  1  slave cycle
- s_wbd_stb_o  out  1  slave strobe

Behaviour:
- Registered owner state: IDLE, OWN0, OWN1. Registered last-served flag.
- Reset (rst_n=0, asynchronous): state=IDLE; last-served=master1, so master0 wins the first tie.
- All slave outputs are 0 during reset and in IDLE.
- All master outputs are 0 during reset and in IDLE.
- IDLE transitions:
  - only m0 cyc -> OWN0
  - only m1 cyc -> OWN1
  - both -> the master not last served
  - grant takes effect next clock; one cycle arbitration latency.
- OWNx: held while mx_cyc_i=1 (bus lock). Other requests are ignored, including across multiple beats and bursts.
- On mx_cyc_i=0 in OWNx (evaluated at the clock edge):
  - if the other master's cyc=1 -> switch directly to its OWN state
  - else -> IDLE
  - last-served updates to x.
- Slave mux (combinational from registered owner):
  - OWN0: s outputs = m0 inputs; s_wbd_bl_o=1; s_wbd_bry_o=1.
  - OWN1: s outputs = m1 inputs, including bl and bry.
  - cyc/stb/we forwarded only from the owner.
- Response routing: owner gets dat_o=s_wbd_dat_i, ack_o=s_wbd_ack_i, lack_o=s_wbd_lack_i.
- Non-owner gets dat_o=0, ack_o=0, lack_o=0.
- err_o is always 0 on both masters; no decode error source exists.
- No address translation; addresses pass unmodified.
- Ack is combinational from the slave with no added latency. Pipelined acks on consecutive cycles pass through.
- Reset mid-transaction: state goes to IDLE immediately, slave cyc drops asynchronously, and no ack reaches either master.
- A master dropping cyc while the slave still acks in that cycle: the ack still routes to the owner, because the state is still OWNx until the clock edge.

Test Plan:
- Reset then m0 read, adr=0x100, cyc/stb=1 -> s_wbd_cyc_o=1 and s_wbd_adr_o=0x100 one cycle later; slave returns dat 0xDEADBEEF, ack=1 -> m0_wbd_dat_o=0xDEADBEEF, m0_wbd_ack_o=1, m1_wbd_ack_o=0.
- m1 write, adr=0x1000, dat=1, we=1, sel=0xF, bl=4, bry=1 -> s_wbd_we_o=1, s_wbd_dat_o=1, s_wbd_bl_o=4, s_wbd_sel_o=0xF.
- Both raise cyc in the same cycle right after reset -> m0 granted first. After m0 drops cyc with m1 still requesting -> OWN1 next cycle. Simultaneous requests again -> m0 wins.
- m1 holds cyc for 4 acked beats while m0 requests -> m0 sees no ack and no s_wbd_adr_o change until m1 drops cyc.
- rst_n pulsed low while OWN1 with stb=1 -> s_wbd_cyc_o=0 immediately, m1_wbd_ack_o=0; after release, first requester gets the grant.
- IDLE with slave ack forced to 1 -> both m*_ack_o=0, both m*_err_o=0.
